// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin burst arbiter.
//   arb_state_e  : FSM encoding (IDLE = 0, BUSY = 1)
//   RR_PTR_RESET : reset value of the one-hot priority pointer (master 0 first)
//   onehot2bin   : one-hot to binary index conversion for grant_idx_o
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned RR_PTR_RESET = 1;

  // Works for any one-hot vector up to 32 bits; callers cast to their width.
  function automatic logic [31:0] onehot2bin(input logic [31:0] oh);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) b = b | 32'(i);
    return b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin one-hot pick.
//   req_i  : request vector
//   ptr_i  : one-hot priority pointer (highest-priority position)
//   pick_o : one-hot winner, first request at or above ptr_i, wrapping
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] pick_o
);

  logic [2*N-1:0] dbl, dif, msk;

  // Doubling the request vector lets the subtract borrow run past the MSB
  // into the second copy, which is how the wrap-around is handled.
  always_comb begin
    dbl    = {req_i, req_i};
    dif    = dbl - {{N{1'b0}}, ptr_i};
    msk    = dbl & ~dif;
    pick_o = msk[N-1:0] | msk[2*N-1:N];
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin, burst-granular arbiter sharing one valid/ready stream port
// between REQUIRE_NUM masters. Ownership changes only at burst end; one
// bubble cycle (IDLE) separates consecutive bursts.
// Optional: ARB_BEAT_LIMIT_EN caps a grant at MAX_BURST beats, forcing
// m_last_o on the final allowed beat and pulsing limit_err_o afterwards.
// Ports:
//   sys_clk_i, rst_n_i (async, active-low)
//   req_valid_i/req_last_i/req_data_i/req_ready_o : per-master stream
//   m_valid_o/m_last_o/m_data_o/m_ready_i         : shared stream
//   grant_o (one-hot owner, 0 when idle), grant_idx_o (binary owner)
//   limit_err_o (only with ARB_BEAT_LIMIT_EN)
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int REQUIRE_NUM = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BURST   = 16
) (
  input  logic                              sys_clk_i,
  input  logic                              rst_n_i,
  input  logic [REQUIRE_NUM-1:0]            req_valid_i,
  input  logic [REQUIRE_NUM-1:0]            req_last_i,
  input  logic [REQUIRE_NUM*DATA_WIDTH-1:0] req_data_i,
  output logic [REQUIRE_NUM-1:0]            req_ready_o,
  output logic                              m_valid_o,
  output logic                              m_last_o,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  input  logic                              m_ready_i,
`ifdef ARB_BEAT_LIMIT_EN
  output logic                              limit_err_o,
`endif
  output logic [REQUIRE_NUM-1:0]            grant_o,
  output logic [$clog2(REQUIRE_NUM)-1:0]    grant_idx_o
);

  localparam int IDX_W = $clog2(REQUIRE_NUM);

  arb_state_e             state_q, state_d;
  logic [REQUIRE_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [REQUIRE_NUM-1:0] ptr_q, ptr_d;
  logic [REQUIRE_NUM-1:0] pick;
  logic                   raw_last, xfer;

  rr_pick #(.N(REQUIRE_NUM)) u_pick (
    .req_i  (req_valid_i),
    .ptr_i  (ptr_q),
    .pick_o (pick)
  );

  // Datapath: grant_q is zero in IDLE, so nothing moves there.
  always_comb begin
    m_data_o = '0;
    for (int k = 0; k < REQUIRE_NUM; k++)
      if (grant_q[k]) m_data_o = m_data_o | req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign m_valid_o   = |(grant_q & req_valid_i);
  assign raw_last    = |(grant_q & req_last_i);
  assign req_ready_o = grant_q & {REQUIRE_NUM{m_ready_i}};
  assign xfer        = m_valid_o & m_ready_i;
  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;

`ifdef ARB_BEAT_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             lim_hit;

  assign lim_hit     = (cnt_q == CNT_W'(MAX_BURST - 1));
  assign m_last_o    = raw_last | (m_valid_o & lim_hit);
  assign limit_err_o = err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)  cnt_d = '0;
    else if (xfer)        cnt_d = cnt_q + 1'b1;
    // Pulse only when the limit, not the master, ended the burst.
    err_d = xfer & lim_hit & ~raw_last;
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign m_last_o = raw_last;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          grant_d = pick;
          idx_d   = IDX_W'(onehot2bin(32'(pick)));
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer && m_last_o) begin
          // Next priority goes to the master just above the finished owner.
          ptr_d   = {grant_q[REQUIRE_NUM-2:0], grant_q[REQUIRE_NUM-1]};
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= REQUIRE_NUM'(RR_PTR_RESET);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
